// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parametrised single-clock FIFO family.
package fifo_pkg;

  typedef enum logic {
    REG_READ   = 1'b0,
    SHOW_AHEAD = 1'b1
  } read_mode_e;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);
  localparam int PTR_W     = DEF_AW + 1;
  localparam int CNT_W     = DEF_AW + 1;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// FIFO storage: WIDTH x DEPTH array, synchronous write, asynchronous read.
// Zero-cycle read path; no flow control of its own, the owner gates the write enable.
module fifo_dpram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO; 1-cycle registered read or show-ahead head output.
// Writes into a full FIFO and reads from an empty one are dropped and flagged sticky.
module param_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = DEPTH - 1,
  parameter int AEMPTY_TH  = 1,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   wn,
  input  logic [WIDTH-1:0]                       DATAIN,
  input  logic                                   rn,
  output logic [WIDTH-1:0]                       DATAOUT,
  output logic                                   dout_valid,
  output logic                                   full,
  output logic                                   empty,
  output logic                                   almost_full,
  output logic                                   almost_empty,
  output logic [fifo_pkg::addr_w(DEPTH):0]       count,
  output logic                                   overflow,
  output logic                                   underflow
);
  import fifo_pkg::*;

  localparam int AW    = addr_w(DEPTH);
  localparam int P_W   = AW + 1;
  localparam int C_W   = AW + 1;
  localparam read_mode_e MODE = (SHOW_AHEAD != 0) ? fifo_pkg::SHOW_AHEAD : REG_READ;

  if (!is_pow2(DEPTH) || WIDTH < 1) begin : g_bad_param
    $error("param_sync_fifo: DEPTH must be a power of two >= 2 and WIDTH >= 1");
  end

  logic [P_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [C_W-1:0]   count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvld_q, dvld_d;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ok, wr_ok;

  assign full         = (count_q == C_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AFULL_TH);
  assign almost_empty = (int'(count_q) <= AEMPTY_TH);

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign rd_ok = rn & ~empty;
  assign wr_ok = wn & (~full | rd_ok);

  fifo_dpram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clock),
    .we    (wr_ok & ~clear),
    .waddr (wptr_q[AW-1:0]),
    .wdata (DATAIN),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + P_W'(1);
      if (rd_ok) begin
        rptr_d = rptr_q + P_W'(1);
        dout_d = rd_data;
        dvld_d = 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + C_W'(1);
        2'b01:   count_d = count_q - C_W'(1);
        default: count_d = count_q;
      endcase
      if (wn & ~wr_ok) ovf_d = 1'b1;
      if (rn & ~rd_ok) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
    end
  end

  // Show-ahead falls back to the last registered word while empty so unwritten slots never leak out.
  assign DATAOUT    = (MODE == fifo_pkg::SHOW_AHEAD) ? (empty ? dout_q : rd_data) : dout_q;
  assign dout_valid = (MODE == fifo_pkg::SHOW_AHEAD) ? ~empty : dvld_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: three instances (default, custom thresholds, show-ahead) share one stimulus.
module tb_param_sync_fifo;
  localparam int D = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       wn = 1'b0, rn = 1'b0;
  logic [7:0] DATAIN = 8'h00;

  logic [7:0] r_dout, t_dout, s_dout;
  logic       r_dvld, t_dvld, s_dvld, r_full, t_full, s_full, r_empty, t_empty, s_empty;
  logic       r_af, t_af, s_af, r_ae, t_ae, s_ae, r_ovf, t_ovf, s_ovf, r_unf, t_unf, s_unf;
  logic [3:0] r_cnt, t_cnt, s_cnt;

  always #5 clock = ~clock;

  param_sync_fifo #(.WIDTH(8), .DEPTH(D)) u_reg (
    .clock(clock), .reset(reset), .clear(clear), .wn(wn), .DATAIN(DATAIN), .rn(rn),
    .DATAOUT(r_dout), .dout_valid(r_dvld), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_cnt), .overflow(r_ovf), .underflow(r_unf));

  param_sync_fifo #(.WIDTH(8), .DEPTH(D), .AFULL_TH(6), .AEMPTY_TH(2)) u_thr (
    .clock(clock), .reset(reset), .clear(clear), .wn(wn), .DATAIN(DATAIN), .rn(rn),
    .DATAOUT(t_dout), .dout_valid(t_dvld), .full(t_full), .empty(t_empty),
    .almost_full(t_af), .almost_empty(t_ae), .count(t_cnt), .overflow(t_ovf), .underflow(t_unf));

  param_sync_fifo #(.WIDTH(8), .DEPTH(D), .SHOW_AHEAD(1)) u_sa (
    .clock(clock), .reset(reset), .clear(clear), .wn(wn), .DATAIN(DATAIN), .rn(rn),
    .DATAOUT(s_dout), .dout_valid(s_dvld), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_unf));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the registered-read output word.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_dvld = 1'b0;
  logic [7:0] m_dout = 8'h00;

  always @(negedge reset) begin
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dvld = 1'b0; m_dout = 8'h00;
  end

  always @(posedge clock) begin : model
    bit rd_ok, wr_ok;
    if (reset) begin
      if (clear) begin
        mq.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dvld = 1'b0;
      end else begin
        rd_ok = rn && (mq.size() > 0);
        wr_ok = wn && ((mq.size() < D) || rd_ok);
        if (wn && !wr_ok) m_ovf = 1'b1;
        if (rn && !rd_ok) m_unf = 1'b1;
        m_dvld = rd_ok;
        if (rd_ok) m_dout = mq.pop_front();
        if (wr_ok) mq.push_back(DATAIN);
      end
    end
  end

  task automatic compare_all();
    int n;
    n = mq.size();
    check("r_count", 32'(r_cnt), n); check("t_count", 32'(t_cnt), n); check("s_count", 32'(s_cnt), n);
    check("r_full", r_full, n == D); check("t_full", t_full, n == D); check("s_full", s_full, n == D);
    check("r_empty", r_empty, n == 0); check("t_empty", t_empty, n == 0); check("s_empty", s_empty, n == 0);
    check("r_afull", r_af, n >= 7); check("s_afull", s_af, n >= 7); check("t_afull", t_af, n >= 6);
    check("r_aempty", r_ae, n <= 1); check("s_aempty", s_ae, n <= 1); check("t_aempty", t_ae, n <= 2);
    check("r_ovf", r_ovf, m_ovf); check("t_ovf", t_ovf, m_ovf); check("s_ovf", s_ovf, m_ovf);
    check("r_unf", r_unf, m_unf); check("t_unf", t_unf, m_unf); check("s_unf", s_unf, m_unf);
    check("r_dvld", r_dvld, m_dvld); check("t_dvld", t_dvld, m_dvld);
    check("r_dout", r_dout, m_dout); check("t_dout", t_dout, m_dout);
    check("s_dvld", s_dvld, n > 0);
    if (n > 0) check("s_dout", s_dout, mq[0]);
  endtask

  always @(posedge clock) begin
    #2;
    compare_all();
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    @(negedge clock);
    wn = w; DATAIN = d; rn = r; clear = c;
  endtask

  task automatic sample();
    @(posedge clock);
    #3;
  endtask

  initial begin
    #2;
    check("rst_count", 32'(r_cnt), 0); check("rst_empty", r_empty, 1); check("rst_full", r_full, 0);
    check("rst_dvld", r_dvld, 0); check("rst_dout", r_dout, 8'h00);
    check("rst_aempty", r_ae, 1); check("rst_afull", r_af, 0); check("rst_ovf", r_ovf, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Reset mid-stream with five entries stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    sample();
    check("pre_rst_count", 32'(r_cnt), 5); check("pre_rst_sa_dvld", s_dvld, 1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_count", 32'(r_cnt), 0); check("async_rst_empty", r_empty, 1);
    check("async_rst_dvld", r_dvld, 0); check("async_rst_sa_dvld", s_dvld, 0);
    @(negedge clock);
    reset = 1'b1;

    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    sample();
    check("a5_dout", r_dout, 8'hA5); check("a5_dvld", r_dvld, 1);

    // Fill, overflow, then concurrent read/write while full.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    sample();
    check("fill_count", 32'(r_cnt), 8); check("fill_full", r_full, 1);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    sample();
    check("ovf_set", r_ovf, 1); check("ovf_count", 32'(r_cnt), 8);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    sample();
    check("rw_full_count", 32'(r_cnt), 8); check("rw_full_dout", r_dout, 8'h04);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    sample();
    check("drain_last", r_dout, 8'h13); check("drain_empty", r_empty, 1);

    // Write/read pairs carry both pointers across their wrap.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    sample();
    check("wrap_last", r_dout, 8'h2F);

    // Concurrent read/write on empty: write lands, read is rejected.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    sample();
    check("rw_empty_count", 32'(r_cnt), 1); check("rw_empty_unf", r_unf, 1); check("rw_empty_dvld", r_dvld, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    sample();
    check("rw_empty_data", r_dout, 8'h77);

    step(1'b0, 8'h00, 1'b0, 1'b1);
    sample();
    check("clr_unf", r_unf, 0); check("clr_ovf", r_ovf, 0);

    // Threshold flags on the custom instance while stepping 0 -> 8 -> 0.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      sample();
      check("thr_up_ae", t_ae, i <= 2); check("thr_up_af", t_af, i >= 6);
    end
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      sample();
      check("thr_dn_ae", t_ae, i <= 2); check("thr_dn_af", t_af, i >= 6);
    end

    // Show-ahead: head visible one cycle after the write, gone after the pop.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    sample();
    check("sa_dvld", s_dvld, 1); check("sa_dout", s_dout, 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    sample();
    check("sa_pop_empty", s_empty, 1); check("sa_pop_dvld", s_dvld, 0);

    // Flush with count=5 and overflow set; the coincident write is dropped.
    for (int i = 0; i < 9; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    sample();
    check("pre_flush_count", 32'(r_cnt), 5); check("pre_flush_ovf", r_ovf, 1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    sample();
    check("flush_count", 32'(r_cnt), 0); check("flush_empty", r_empty, 1);
    check("flush_ovf", r_ovf, 0); check("flush_dvld", r_dvld, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    sample();
    check("flush_dropped_unf", r_unf, 1); check("flush_dropped_dvld", r_dvld, 0);

    step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) sample();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO. It is the next generation of the team's fixed 8x8 linear queue.
- Generalised in WIDTH and DEPTH. Adds pointer wrap-around, a simultaneous read and write in one cycle, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and an optional show-ahead read mode.
- Sits between a producer and a consumer datapath in the same clock domain.

Parameters:
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 8: number of entries. Must be a power of two, ≥2. Any other value fails elaboration.
- AFULL_TH, DEPTH-1: almost_full asserts when count ≥ AFULL_TH.
- AEMPTY_TH, 1: almost_empty asserts when count ≤ AEMPTY_TH.
- SHOW_AHEAD, 0: selects the read mode.
  - 0 = registered read: data appears on DATAOUT the cycle after the read is accepted.
  - 1 = first-word-fall-through: DATAOUT always shows the head entry when the FIFO is not empty.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Assert asynchronously; release synchronously to clock.
- clear  in  1  synchronous flush, active-high.
- wn  in  1  write request.
- DATAIN  in  WIDTH  write data.
- rn  in  1  read request.
- DATAOUT  out  WIDTH  read data.
- dout_valid  out  1  DATAOUT holds valid read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_TH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- count  out  AW+1  occupancy, 0..DEPTH, where AW = log2(DEPTH).
- overflow  out  1  sticky: a write was attempted while full and rejected.
- underflow  out  1  sticky: a read was attempted while empty and rejected.

Behaviour:
- Reset (reset=0), effective immediately:
  - wptr=rptr=0, count=0, DATAOUT=0, dout_valid=0.
  - overflow=underflow=0, empty=1, full=0.
  - almost_empty=1, almost_full=0 (assuming AFULL_TH>0).
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data.
- Pointers:
  - wptr and rptr are AW+1 bits wide. The MSB is a wrap bit.
  - Low AW bits equal with MSBs different means full. Pointers fully equal means empty.
  - Pointers increment modulo 2^(AW+1).
- Write acceptance: wr_ok = wn & (!full | rd_ok). Writing while full is allowed when a read is accepted in the same cycle.
- Read acceptance: rd_ok = rn & !empty. A read on empty is rejected, even if a write arrives in the same cycle.
- count update:
  - +1 on wr_ok & !rd_ok.
  - −1 on rd_ok & !wr_ok.
  - Unchanged when both or neither are accepted.
- Flags full, empty, almost_full and almost_empty:
  - Derived combinationally from registered count/pointers.
  - Valid in the same cycle the registered state changes, i.e. one cycle after the accepted operation.
- overflow is set on wn & !wr_ok. underflow is set on rn & !rd_ok.
- overflow and underflow clear only on reset or clear.
- SHOW_AHEAD=0:
  - On rd_ok, DATAOUT <= mem[rptr] and dout_valid <= 1 at the next edge.
  - Otherwise dout_valid <= 0 and DATAOUT holds its value.
  - Read latency is 1 cycle.
- SHOW_AHEAD=1:
  - DATAOUT = mem[rptr[AW-1:0]], combinational from registered memory and pointer.
  - dout_valid = !empty.
  - rn pops the head entry.
  - A write into an empty FIFO becomes visible one cycle after the write edge.
- Same-address case: a simultaneous read and write when full addresses the same slot.
  - The read returns the old data.
  - The memory is written at the same edge.
- clear (when reset=1):
  - Has priority over wn and rn.
  - Sets pointers, count and error flags to 0, and dout_valid to 0. DATAOUT holds its value.
  - Any write in that cycle is dropped and not flagged.
- No X propagation: DATAOUT never presents unwritten memory while dout_valid=1.

Decomposition:
- Shared package fifo_pkg:
  - Function clog2-based address width helper.
  - Localparams PTR_W = AW+1 and CNT_W = AW+1.
  - Enum read_mode_e {REG_READ=0, SHOW_AHEAD=1}.
- One sub-module, fifo_dpram:
  - Parametrised WIDTH × DEPTH storage.
  - One synchronous write port and one asynchronous read port.
  - No reset on the array.
- Top level holds the pointers, count, flags and output register.

Test Plan:
- Reset and flags:
  - Stimulus: DEPTH=8; assert reset=0 mid-stream with count=5.
  - Required response: count=0, empty=1, dout_valid=0 immediately, without waiting for a clock.
  - After release: a write of 8'hA5 followed by a read gives DATAOUT=8'hA5 one cycle after rn (SHOW_AHEAD=0).
- Fill, overflow and wrap-around:
  - Stimulus: write 0x01..0x08.
  - Required response: full=1 and count=8.
  - Stimulus: a 9th write of 0x09.
  - Required response: overflow=1 and count stays 8.
  - Stimulus: read all 8 entries, then write and read 16 more values.
  - Required response: data comes out in order across the pointer wrap.
- Simultaneous read and write:
  - Stimulus: while full, wn=rn=1 for 4 cycles with DATAIN 0x10..0x13.
  - Required response: count stays 8, outputs are 0x01..0x04, and 0x10..0x13 later emerge after 0x05..0x08.
  - Stimulus: on empty, wn=rn=1.
  - Required response: count becomes 1, underflow=1, dout_valid=0.
- Threshold flags:
  - Stimulus: AFULL_TH=6, AEMPTY_TH=2; step count 0→8→0.
  - Required response: almost_empty is 1 exactly for count 0..2 and almost_full is 1 exactly for count 6..8, each tracking count with no lag.
- Show-ahead mode:
  - Stimulus: SHOW_AHEAD=1; write 0x3C into an empty FIFO.
  - Required response: the next cycle has dout_valid=1 and DATAOUT=0x3C.
  - Stimulus: rn=1.
  - Required response: the next cycle has empty=1 and dout_valid=0.
- Flush:
  - Stimulus: count=5 with overflow=1; pulse clear together with wn=1.
  - Required response: the next cycle has count=0, empty=1, overflow=0, and the write is dropped.
